// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: drives PC and inter-stage
// register enables/flushes, tracks stall/flush counts and a sticky memory timeout.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_halt,
  input  logic                  dbg_step_mode,
  input  logic                  dbg_step,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic                  halted,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, HALTED} state_e;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;

  logic active, mem_stall, step_freeze, load_use, rs1_hit, rs2_hit;
  logic stall_inc, flush_inc;

  assign active      = (state_q == RUN) || (state_q == MEM_WAIT);
  assign mem_stall   = mem_req & ~mem_ready;
  assign step_freeze = dbg_step_mode & ~dbg_step;
  assign rs1_hit     = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit     = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use    = ex_is_load & ex_reg_write & (ex_rd != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    unique case (state_q)
      INIT: begin
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        mem_wb_bubble = 1'b1;
        state_d       = RUN;
      end
      HALTED: halted = 1'b1;
      default: begin
        if (mem_stall) begin
          mem_wb_en     = 1'b1;
          mem_wb_bubble = 1'b1;
          stall_inc     = 1'b1;
          state_d       = MEM_WAIT;
        end else begin
          // halt only takes effect once memory is not holding the pipe
          state_d = wb_halt ? HALTED : RUN;
          if (!step_freeze) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_branch_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              flush_inc   = 1'b1;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
              stall_inc   = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    stall_d   = (stall_inc && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d   = (flush_inc && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (active && mem_stall) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_q == WAIT_LAST) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      stall_q   <= '0;
      flush_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a reference model pushes the
// expected outputs for each driven cycle; they are popped and compared mid-cycle.
module tb_pipeline_hazard_controller;

  localparam int RW = 3;
  localparam int CW = 4;
  localparam int MT = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_reg_write, ex_branch_taken;
  logic          mem_req, mem_ready, wb_halt, dbg_step_mode, dbg_step;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble, halted, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_controller #(
    .REG_ADDR_W (RW),
    .CNT_W      (CW),
    .MEM_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_halt(wb_halt), .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id_flush, id_ex_flush, mem_wb_bubble}
  typedef struct packed {
    logic [4:0]    en;
    logic [2:0]    fl;
    logic          hlt;
    logic          to;
    logic [CW-1:0] st;
    logic [CW-1:0] fc;
  } exp_t;

  typedef enum int {M_INIT, M_RUN, M_WAIT, M_HALT} mstate_t;

  exp_t    sbq[$];
  int      checks = 0;
  int      failures = 0;
  mstate_t ms, n_ms;
  int      m_st, m_fc, m_wc, n_st, n_fc, n_wc;
  bit      m_to, n_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = M_INIT; m_st = 0; m_fc = 0; m_wc = 0; m_to = 0;
  endtask

  function automatic bit lu_cond();
    return ex_is_load && ex_reg_write && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic predict(output exp_t e);
    bit stall_pc;
    e = '0;
    n_ms = ms; n_st = m_st; n_fc = m_fc; n_wc = 0; n_to = m_to;
    e.hlt = (ms == M_HALT);
    e.to = m_to; e.st = m_st[CW-1:0]; e.fc = m_fc[CW-1:0];
    stall_pc = 0;
    if (ms == M_INIT) begin
      e.fl = 3'b111; n_ms = M_RUN;
    end else if (ms != M_HALT) begin
      if (mem_req && !mem_ready) begin
        e.en = 5'b00001; e.fl = 3'b001; n_ms = M_WAIT; stall_pc = 1;
        n_wc = (m_wc < MT) ? m_wc + 1 : MT;
        if (n_wc >= MT) n_to = 1;
      end else begin
        n_ms = wb_halt ? M_HALT : M_RUN;
        if (dbg_step_mode && !dbg_step) e.en = 5'b00000;
        else if (ex_branch_taken) begin
          e.en = 5'b11111; e.fl = 3'b110;
          n_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else if (lu_cond()) begin
          e.en = 5'b00111; e.fl = 3'b010; stall_pc = 1;
        end else e.en = 5'b11111;
      end
      if (stall_pc) n_st = (m_st < CMAX) ? m_st + 1 : CMAX;
    end
  endtask

  // Inputs are already driven (just after a negedge); predict, push, then pop and compare.
  task automatic step(input string tag);
    exp_t e, x;
    #1;
    if (!rst_n) model_reset();
    predict(e);
    sbq.push_back(e);
    #2;
    x = sbq.pop_front();
    check_val({tag, "_en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, x.en});
    check_val({tag, "_fl"}, {29'd0, if_id_flush, id_ex_flush, mem_wb_bubble}, {29'd0, x.fl});
    check_val({tag, "_halted"}, {31'd0, halted}, {31'd0, x.hlt});
    check_val({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, x.to});
    check_val({tag, "_stall"}, {28'd0, stall_cycles}, {28'd0, x.st});
    check_val({tag, "_flush"}, {28'd0, flush_count}, {28'd0, x.fc});
    @(posedge clk);
    if (rst_n) begin
      ms = n_ms; m_st = n_st; m_fc = n_fc; m_wc = n_wc; m_to = n_to;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0; ex_reg_write = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0; wb_halt = 0;
    dbg_step_mode = 0; dbg_step = 0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 3'd3; id_rs2 = 3'd3; id_uses_rs2 = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; step("rst");
    rst_n = 1; step("init");
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);

    // reset held, release, one INIT cycle, then RUN
    step("rst_hold0"); step("rst_hold1");
    rst_n = 1; step("init_cycle");
    step("run0");
    check_val("run_stall_zero", {28'd0, stall_cycles}, 32'd0);

    // load-use: one bubble; ex_rd=0 gives no stall
    set_load_use(); step("lu");
    idle_inputs(); step("lu_after");
    check_val("lu_stall_one", {28'd0, stall_cycles}, 32'd1);
    set_load_use(); ex_rd = 3'd0; id_rs2 = 3'd0; step("lu_rd0");
    idle_inputs(); step("lu_rd0_after");
    check_val("lu_rd0_no_stall", {28'd0, stall_cycles}, 32'd1);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 3'd5; id_rs1 = 3'd5; id_uses_rs1 = 1; step("lu_rs1");
    id_uses_rs1 = 0; step("lu_rs1_unused");
    idle_inputs();

    // branch wins over load-use
    set_load_use(); ex_branch_taken = 1; step("br_lu");
    idle_inputs(); step("br_after");
    check_val("br_flush_one", {28'd0, flush_count}, 32'd1);
    check_val("br_stall_same", {28'd0, stall_cycles}, 32'd2);

    // memory stall of 5 cycles, timeout at the 4th
    do_reset();
    mem_req = 1;
    for (int unsigned i = 0; i < 5; i++) step("mem_wait");
    mem_ready = 1; step("mem_done");
    idle_inputs(); step("mem_after");
    check_val("mem_stall_five", {28'd0, stall_cycles}, 32'd5);
    check_val("mem_timeout_sticky", {31'd0, mem_timeout}, 32'd1);

    // short stall: counter clears between stalls, no timeout
    do_reset();
    mem_req = 1;
    for (int unsigned i = 0; i < 3; i++) step("mem_short");
    mem_ready = 1; step("mem_short_done");
    mem_ready = 0;
    for (int unsigned i = 0; i < 3; i++) step("mem_short2");
    idle_inputs(); step("mem_short_after");
    check_val("mem_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // reset asserted mid-stall takes effect immediately
    mem_req = 1; step("mid_stall");
    #2 rst_n = 0; #1;
    check_val("async_rst_pc_en", {31'd0, pc_en}, 32'd0);
    check_val("async_rst_flush", {31'd0, id_ex_flush}, 32'd1);
    check_val("async_rst_stall", {28'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    idle_inputs(); step("rst_mid");
    rst_n = 1; step("init_mid"); step("run_mid");

    // branch + memory stall: freeze, branch taken when ready arrives; halt ignored while stalled
    ex_branch_taken = 1; mem_req = 1; wb_halt = 1; step("br_mem0");
    wb_halt = 0; step("br_mem1");
    mem_ready = 1; step("br_mem_done");
    idle_inputs(); step("br_mem_after");

    // debug single-step: 3 pulses over 10 cycles
    do_reset();
    dbg_step_mode = 1;
    for (int unsigned i = 0; i < 10; i++) begin
      dbg_step = (i == 1 || i == 4 || i == 7);
      set_load_use();
      if (i != 4) begin ex_is_load = 0; end
      step("dbg");
    end
    idle_inputs(); step("dbg_after");
    check_val("dbg_stall_count", {28'd0, stall_cycles}, 32'd1);

    // saturation of both counters
    mem_req = 1;
    for (int unsigned i = 0; i < 18; i++) step("sat_stall");
    idle_inputs(); ex_branch_taken = 1;
    for (int unsigned i = 0; i < 17; i++) step("sat_flush");
    idle_inputs(); step("sat_after");
    check_val("sat_stall_max", {28'd0, stall_cycles}, CMAX);
    check_val("sat_flush_max", {28'd0, flush_count}, CMAX);

    // halt: held 20 cycles, reset returns to INIT
    wb_halt = 1; step("halt_req");
    wb_halt = 0; ex_branch_taken = 1; mem_req = 1;
    for (int unsigned i = 0; i < 20; i++) step("halted");
    check_val("halt_flag", {31'd0, halted}, 32'd1);
    idle_inputs();
    rst_n = 0; step("halt_rst");
    check_val("halt_rst_cleared", {31'd0, halted}, 32'd0);
    rst_n = 1; step("halt_init"); step("halt_run");

    check_val("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB) of the 16-bit RISC core. It drives the enable and flush controls of the PC and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken branches, multi-cycle data-memory waits, debug single-step and halt. It also keeps saturating stall/flush counters and a sticky memory-timeout flag.

## Interface
- REG_ADDR_W, 3: register-address width
- CNT_W, 16: width of performance counters
- MEM_TIMEOUT, 64: consecutive memory-wait cycles before mem_timeout sets (≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_is_load, ex_reg_write  in  1  EX instruction is a load / writes a register
- ex_rd  in  REG_ADDR_W  destination of EX instruction
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req, mem_ready  in  1  MEM stage data-memory request / completion
- wb_halt  in  1  halt instruction in WB
- dbg_step_mode, dbg_step  in  1  single-step enable / one-cycle advance pulse
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register captures its input
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1  register captures all-zero NOP (overrides en)
- halted  out  1  in HALTED state
- mem_timeout  out  1  sticky: a memory wait reached MEM_TIMEOUT
- stall_cycles, flush_count  out  CNT_W  saturating counters

## Operation
- States: INIT, RUN, MEM_WAIT, HALTED. State register reset to INIT asynchronously.
- INIT: all enables 0; if_id_flush=id_ex_flush=mem_wb_bubble=1; next RUN. These are the output values during reset. Counters and mem_timeout reset to 0.
- HALTED: all enables 0, all flushes 0, halted=1. Left only by reset.
- RUN and MEM_WAIT: outputs are combinational from state and inputs, evaluated in this priority (first match wins):
  1. Memory stall (mem_req & !mem_ready). pc/if_id/id_ex/ex_mem en=0. mem_wb_en=1 with mem_wb_bubble=1. Next state MEM_WAIT.
  2. Step freeze (dbg_step_mode & !dbg_step). All enables 0, no flushes. Stall counter is not incremented.
  3. Taken branch (ex_branch_taken). All enables 1; if_id_flush=id_ex_flush=1; flush_count+1.
  4. Load-use. Condition: ex_is_load & ex_reg_write & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). pc_en=if_id_en=0; id_ex_flush=1; ex_mem_en=mem_wb_en=1.
  5. Otherwise all enables 1, no flushes.
- MEM_WAIT returns to RUN in the cycle mem_ready=1. That cycle is evaluated by rules 2–5.
- wb_halt is acted on only in a cycle where rule 1 does not apply. Next state HALTED; this overrides any RUN/MEM_WAIT transition.
- stall_cycles increments in every RUN/MEM_WAIT cycle with pc_en=0, except rule 2 cycles. It saturates at 2^CNT_W−1. flush_count also saturates.
- Memory-wait counter: counts consecutive rule-1 cycles and clears when rule 1 is not active. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set; the stall continues.

## Timing
- Zero-cycle combinational path from hazard inputs to enables/flushes. State, counters and mem_timeout update on the rising clk edge.
- Load-use inserts exactly 1 bubble. Taken branch costs 2 flushed slots. A memory stall costs N cycles for a mem_ready arriving N cycles after mem_req.
- Branch + load-use in the same cycle: branch wins; no stall.
- Branch + memory stall: freeze; the branch is re-evaluated when mem_ready arrives.
- rst_n asserted mid-stall or mid-halt: immediate INIT outputs and counter clear. After the release edge: one INIT cycle, then RUN.

## Test plan
- Reset then release: INIT outputs hold (pc_en=0, flushes=1) while rst_n=0. One INIT cycle follows release, then RUN with all en=1 and stall_cycles=0.
- EX lw r3, ID add uses rs2=r3: exactly 1 cycle with pc_en=if_id_en=0 and id_ex_flush=1; stall_cycles=1. The same case with ex_rd=0 gives no stall.
- ex_branch_taken=1 together with the load-use condition: if_id_flush=id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- mem_req=1 with mem_ready asserted 5 cycles later: 5 freeze cycles with mem_wb_bubble=1, then RUN; stall_cycles=5. With MEM_TIMEOUT=4, mem_timeout sets at the 4th stall cycle and stays set.
- dbg_step_mode=1 with 3 dbg_step pulses over 10 cycles: enables are 1 only in the 3 pulse cycles; stall_cycles unchanged.
- wb_halt=1: HALTED next cycle with all en=0 and halted=1, held for 20 cycles. Asserting rst_n low returns to INIT.
